// File: rtl/ic_regmux_pkg.sv
// Shared types and helpers for the registered N-channel multiplexer (ic_regmux).
// Used by the RTL and the bench so the select-update priority has one vocabulary.
package ic_regmux_pkg;

   // Which rule updates the select register on a given edge, highest priority first.
   typedef enum logic [1:0] {
      SEL_RESET = 2'd0,
      SEL_LOAD  = 2'd1,
      SEL_SCAN  = 2'd2,
      SEL_HOLD  = 2'd3
   } sel_decision_e;

   function automatic int sel_width(input int channels);
      int w;
      w = $clog2(channels);
      return (w < 32'sd1) ? 32'sd1 : w;
   endfunction

endpackage

// File: rtl/ic_regmux_sel_counter.sv
// Select register for ic_regmux with scan increment and a one-cycle wrap pulse.
// Only instantiated when IC_REGMUX_SCAN_EN is defined.
module ic_regmux_sel_counter
   import ic_regmux_pkg::*;
#(
   parameter int CHANNELS = 8,
   parameter int SEL_W    = sel_width(CHANNELS)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [SEL_W-1:0] sel_in,
   input  logic             sel_load,
   input  logic             scan,
   output logic [SEL_W-1:0] sel,
   output logic             wrap
);

   localparam int               LAST_I = CHANNELS - 1;
   localparam logic [SEL_W-1:0] LAST_C = LAST_I[SEL_W-1:0];

   sel_decision_e    decision_s;
   logic [SEL_W-1:0] sel_r;
   logic [SEL_W-1:0] sel_next_s;
   logic             wrap_r;
   logic             wrap_next_s;

   // Resolve which update rule applies this edge.
   always_comb begin
      decision_s = SEL_HOLD;
      if (!reset_n) begin
         decision_s = SEL_RESET;
      end else if (sel_load) begin
         decision_s = SEL_LOAD;
      end else if (scan) begin
         decision_s = SEL_SCAN;
      end else begin
         decision_s = SEL_HOLD;
      end
   end

   // Next select value; anything at or past the last channel scans back to 0 and flags wrap.
   always_comb begin
      sel_next_s  = sel_r;
      wrap_next_s = 1'b0;
      case (decision_s)
         SEL_RESET: begin
            sel_next_s  = '0;
            wrap_next_s = 1'b0;
         end
         SEL_LOAD: begin
            sel_next_s  = sel_in;
            wrap_next_s = 1'b0;
         end
         SEL_SCAN: begin
            if (sel_r < LAST_C) begin
               sel_next_s  = sel_r + SEL_W'(1'b1);
               wrap_next_s = 1'b0;
            end else begin
               sel_next_s  = '0;
               wrap_next_s = 1'b1;
            end
         end
         SEL_HOLD: begin
            sel_next_s  = sel_r;
            wrap_next_s = 1'b0;
         end
         default: begin
            sel_next_s  = '0;
            wrap_next_s = 1'b0;
         end
      endcase
   end

   // Select and wrap state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sel_r  <= '0;
         wrap_r <= 1'b0;
      end else begin
         sel_r  <= sel_next_s;
         wrap_r <= wrap_next_s;
      end
   end

   assign sel  = sel_r;
   assign wrap = wrap_r;

endmodule

// File: rtl/ic_regmux.sv
// Registered N-channel multiplexer: data and select registers, gated output forced low when disabled.
// Optional scan counter with wrap pulse is compiled in with IC_REGMUX_SCAN_EN.
module ic_regmux
   import ic_regmux_pkg::*;
#(
   parameter  int WIDTH    = 1,
   parameter  int CHANNELS = 8,
   localparam int SEL_W    = sel_width(CHANNELS)
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [CHANNELS*WIDTH-1:0] inputs,
   input  logic                      data_load,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic                      sel_load,
   input  logic                      scan,
   input  logic                      enable_n,
   output logic [WIDTH-1:0]          out,
   output logic [WIDTH-1:0]          out_n,
   output logic [SEL_W-1:0]          sel_out,
   output logic                      wrap
);

   logic [CHANNELS-1:0][WIDTH-1:0] data_r;
   logic [SEL_W-1:0]               sel_s;
   logic                           wrap_s;
   logic [WIDTH-1:0]               out_s;

   // Data register captures every channel at once.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         data_r <= '0;
      end else if (data_load) begin
         data_r <= inputs;
      end else begin
         data_r <= data_r;
      end
   end

`ifdef IC_REGMUX_SCAN_EN
   ic_regmux_sel_counter #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_sel_counter (
      .clock    (clock),
      .reset_n  (reset_n),
      .sel_in   (sel_in),
      .sel_load (sel_load),
      .scan     (scan),
      .sel      (sel_s),
      .wrap     (wrap_s)
   );
`else
   sel_decision_e    decision_s;
   logic [SEL_W-1:0] sel_r;
   logic             unused_scan_s;

   assign unused_scan_s = scan;
   assign wrap_s        = 1'b0;
   assign sel_s         = sel_r;

   // Without scanning only reset and sel_load move the select register.
   always_comb begin
      decision_s = SEL_HOLD;
      if (!reset_n) begin
         decision_s = SEL_RESET;
      end else if (sel_load) begin
         decision_s = SEL_LOAD;
      end else begin
         decision_s = SEL_HOLD;
      end
   end

   // Plain load register for the select value.
   always_ff @(posedge clock) begin
      case (decision_s)
         SEL_RESET: sel_r <= '0;
         SEL_LOAD:  sel_r <= sel_in;
         SEL_HOLD:  sel_r <= sel_r;
         default:   sel_r <= '0;
      endcase
   end
`endif

   // Output mux; out-of-range select values match no channel and read as 0.
   always_comb begin
      out_s = '0;
      if (!enable_n) begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (sel_s == k[SEL_W-1:0]) begin
               out_s = data_r[k];
            end else begin
               out_s = out_s;
            end
         end
      end else begin
         out_s = '0;
      end
   end

   assign out     = out_s;
   assign out_n   = ~out_s;
   assign sel_out = sel_s;
   assign wrap    = wrap_s;

endmodule

// File: tb/tb_ic_regmux.sv
// Self-checking bench for ic_regmux: an 8-channel and a 5-channel instance against a behavioural model.
// Expected scan behaviour follows IC_REGMUX_SCAN_EN as the RTL does.
module tb_ic_regmux;
   import ic_regmux_pkg::*;

`ifdef IC_REGMUX_SCAN_EN
   localparam bit SCAN_EN = 1'b1;
`else
   localparam bit SCAN_EN = 1'b0;
`endif

   logic        clock;
   logic        reset_n;
   logic        data_load;
   logic        sel_load;
   logic        scan;
   logic        enable_n;
   logic [2:0]  sel_in;
   logic [31:0] in8;
   logic [19:0] in5;
   logic [3:0]  out8, out_n8, out5, out_n5;
   logic [2:0]  sel8, sel5;
   logic        wrap8, wrap5;

   int in_val [8];
   int m_data [2][8];
   int m_sel  [2];
   int m_wrap [2];
   int n_assert;
   int n_fail;

   ic_regmux #(.WIDTH(4), .CHANNELS(8)) dut8 (
      .clock(clock), .reset_n(reset_n), .inputs(in8), .data_load(data_load),
      .sel_in(sel_in), .sel_load(sel_load), .scan(scan), .enable_n(enable_n),
      .out(out8), .out_n(out_n8), .sel_out(sel8), .wrap(wrap8)
   );

   ic_regmux #(.WIDTH(4), .CHANNELS(5)) dut5 (
      .clock(clock), .reset_n(reset_n), .inputs(in5), .data_load(data_load),
      .sel_in(sel_in), .sel_load(sel_load), .scan(scan), .enable_n(enable_n),
      .out(out5), .out_n(out_n5), .sel_out(sel5), .wrap(wrap5)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int chans(input int d);
      return (d == 0) ? 8 : 5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < 8; k++) in8[k*4 +: 4] = 4'(in_val[k]);
      for (int k = 0; k < 5; k++) in5[k*4 +: 4] = 4'(in_val[k]);
   endtask

   // Apply the edge rules to the model using the values present at the edge.
   task automatic model_edge();
      sel_decision_e dec;
      for (int d = 0; d < 2; d++) begin
         if (!reset_n) dec = SEL_RESET;
         else if (sel_load) dec = SEL_LOAD;
         else if (scan && SCAN_EN) dec = SEL_SCAN;
         else dec = SEL_HOLD;
         if (!reset_n) begin
            for (int k = 0; k < 8; k++) m_data[d][k] = 0;
         end else if (data_load) begin
            for (int k = 0; k < chans(d); k++) m_data[d][k] = in_val[k] % 16;
         end
         case (dec)
            SEL_RESET: begin m_sel[d] = 0; m_wrap[d] = 0; end
            SEL_LOAD:  begin m_sel[d] = int'(sel_in); m_wrap[d] = 0; end
            SEL_SCAN: begin
               if (m_sel[d] + 1 >= chans(d)) begin m_sel[d] = 0; m_wrap[d] = 1; end
               else begin m_sel[d] = m_sel[d] + 1; m_wrap[d] = 0; end
            end
            default:   m_wrap[d] = 0;
         endcase
      end
   endtask

   task automatic check_all(input string tag);
      int e_out;
      for (int d = 0; d < 2; d++) begin
         e_out = (!enable_n && m_sel[d] < chans(d)) ? m_data[d][m_sel[d]] : 0;
         if (d == 0) begin
            chk({tag, "/out8"},   32'(out8),   32'(e_out));
            chk({tag, "/out_n8"}, 32'(out_n8), 32'(15 - e_out));
            chk({tag, "/sel8"},   32'(sel8),   32'(m_sel[0]));
            chk({tag, "/wrap8"},  32'(wrap8),  32'(m_wrap[0]));
         end else begin
            chk({tag, "/out5"},   32'(out5),   32'(e_out));
            chk({tag, "/out_n5"}, 32'(out_n5), 32'(15 - e_out));
            chk({tag, "/sel5"},   32'(sel5),   32'(m_sel[1]));
            chk({tag, "/wrap5"},  32'(wrap5),  32'(m_wrap[1]));
         end
      end
   endtask

   task automatic tick(input string tag);
      drive_inputs();
      @(posedge clock);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      int exp_sel [4];
      int exp_wrap [4];
      n_assert = 0;
      n_fail   = 0;
      for (int d = 0; d < 2; d++) begin
         m_sel[d] = 0; m_wrap[d] = 0;
         for (int k = 0; k < 8; k++) m_data[d][k] = 0;
      end

      // Reset overrides loads and scan.
      reset_n = 1'b0; data_load = 1'b1; sel_load = 1'b1; sel_in = 3'd5;
      scan = 1'b1; enable_n = 1'b0;
      for (int k = 0; k < 8; k++) in_val[k] = 15;
      tick("reset0");
      tick("reset1");
      chk("reset_out8",   32'(out8),   32'h0);
      chk("reset_out_n8", 32'(out_n8), 32'hF);
      chk("reset_sel8",   32'(sel8),   32'h0);

      // Load data k+1 and select channel 5.
      reset_n = 1'b1; scan = 1'b0;
      for (int k = 0; k < 8; k++) in_val[k] = k + 1;
      tick("load");
      chk("load_out8",   32'(out8),   32'h6);
      chk("load_out_n8", 32'(out_n8), 32'h9);
      chk("load_out5",   32'(out5),   32'h0);

      // Inputs change without data_load: no effect.
      data_load = 1'b0; sel_load = 1'b0;
      for (int k = 0; k < 8; k++) in_val[k] = 15 - k;
      tick("hold");
      chk("hold_out8", 32'(out8), 32'h6);

      // Enable is combinational.
      enable_n = 1'b1;
      #1;
      check_all("disable");
      chk("disable_out_n8", 32'(out_n8), 32'hF);
      enable_n = 1'b0;
      #1;
      check_all("enable");
      chk("enable_out8", 32'(out8), 32'h6);

      // Scan from 3 for four cycles.
      sel_load = 1'b1; sel_in = 3'd3;
      tick("scan_load");
      sel_load = 1'b0; scan = 1'b1;
      if (SCAN_EN) begin
         exp_sel = '{4, 0, 1, 2}; exp_wrap = '{0, 1, 0, 0};
      end else begin
         exp_sel = '{3, 3, 3, 3}; exp_wrap = '{0, 0, 0, 0};
      end
      for (int i = 0; i < 4; i++) begin
         tick("scan");
         chk("scan_sel5",  32'(sel5),  32'(exp_sel[i]));
         chk("scan_wrap5", 32'(wrap5), 32'(exp_wrap[i]));
      end

      // Out-of-range select, scan out of it, then load beats scan.
      scan = 1'b0; sel_load = 1'b1; sel_in = 3'd6;
      tick("oor_load");
      chk("oor_out5", 32'(out5), 32'h0);
      sel_load = 1'b0; scan = 1'b1;
      tick("oor_scan");
      chk("oor_scan_sel5", 32'(sel5), SCAN_EN ? 32'h0 : 32'h6);
      sel_load = 1'b1; sel_in = 3'd2;
      tick("prio");
      chk("prio_sel5",  32'(sel5),  32'h2);
      chk("prio_wrap5", 32'(wrap5), 32'h0);

      // Continuous scan, then reset mid-scan and resume.
      sel_load = 1'b0; scan = 1'b1; data_load = 1'b1;
      for (int i = 0; i < 10; i++) tick("scan10");
      reset_n = 1'b0;
      tick("mid_reset");
      chk("mid_reset_sel8", 32'(sel8), 32'h0);
      reset_n = 1'b1; data_load = 1'b0;
      for (int i = 0; i < 6; i++) tick("resume");

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         reset_n   = ($urandom_range(39, 0) != 0);
         data_load = ($urandom_range(3, 0) == 0);
         sel_load  = ($urandom_range(5, 0) == 0);
         scan      = ($urandom_range(2, 0) != 0);
         enable_n  = ($urandom_range(7, 0) == 0);
         sel_in    = 3'($urandom_range(7, 0));
         for (int k = 0; k < 8; k++) in_val[k] = int'($urandom_range(15, 0));
         tick("rand");
         if ($urandom_range(9, 0) == 0) begin
            enable_n = ~enable_n;
            #1;
            check_all("rand_en");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ic_regmux.md
# ic_regmux

Parametrised registered N-channel multiplexer for the IC model library, extending the 8-to-1 combinational selector with data and select registers (in the style of the 74354 family) and an optional auto-scanning select counter. Used for bus-source selection and time-multiplexed readout (display scanning, register-file read ports) where the selected value must be stable for a whole cycle. All state sits behind one clock. Output gating matches the existing mux models: forced low when disabled.

## Interface
Parameters:
- WIDTH, 1, bits per channel (≥1)
- CHANNELS, 8, number of input channels (≥2, need not be a power of two)
- SEL_W, derived as $clog2(CHANNELS), select width (local, not overridable)

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous active-low reset, sampled on rising clock
- inputs  in  CHANNELS×WIDTH  channel data, index 0..CHANNELS-1
- data_load  in  1  capture all of `inputs` into data register
- sel_in  in  SEL_W  select value to load
- sel_load  in  1  load `sel_in` into select register
- scan  in  1  advance select register by one (scan mode)
- enable_n  in  1  active-low output enable (combinational)
- out  out  WIDTH  selected registered channel, or 0
- out_n  out  WIDTH  bitwise complement of `out`
- sel_out  out  SEL_W  current select register
- wrap  out  1  registered one-cycle pulse: scan advanced from CHANNELS-1 to 0

## Operation
- Data register: CHANNELS×WIDTH; on edge with data_load=1 captures all of `inputs`; otherwise holds.
- Select register (SEL_W), per edge, priority order:
  1. reset_n=0 → 0
  2. sel_load=1 → sel_in (scan ignored that cycle)
  3. scan=1 → sel+1 if sel < CHANNELS-1, else 0
  4. hold
- wrap: 1 for the cycle following an edge on which rule 3 took sel from CHANNELS-1 to 0; also wraps from any out-of-range value (≥CHANNELS) to 0 with wrap=1. sel_load always clears wrap.
- out = (!enable_n && sel < CHANNELS) ? data[sel] : 0; out_n = ~out always (including disabled: out_n all-ones).
- data_load and select updates on the same edge are independent; both take effect together.
- reset_n=0: data register all-zero, sel=0, wrap=0 — overrides any load/scan on the same edge.

## Timing
- Reset values: out=0, out_n=all-ones, sel_out=0, wrap=0 (out stays 0 under enable since data is zero).
- data_load / sel_load / scan → out: 1 cycle (visible after the capturing edge).
- enable_n → out/out_n: combinational, 0 cycles.
- inputs changing without data_load: no effect on out.
- wrap: exactly one cycle wide; back-to-back wraps possible only when CHANNELS… (never for CHANNELS≥2 under continuous scan: period = CHANNELS cycles).
- Reset asserted mid-scan: next edge returns sel to 0 with wrap=0; scanning resumes from 0 after release.

## Configuration
- IC_REGMUX_SCAN_EN defined: scan counter and wrap logic compiled in as above.
- Not defined: `scan` port present but ignored; select register changes only via reset or sel_load; wrap tied to 0. Out-of-range sel via sel_load still yields out=0.

## Structure
- Shared package ic_regmux_pkg: function sel_width(channels) returning $clog2 with minimum 1; typedef for the priority decision enum (SEL_RESET, SEL_LOAD, SEL_SCAN, SEL_HOLD) used by RTL and bench.
- One sub-module: ic_regmux_sel_counter (select register + increment/wrap + wrap pulse), instantiated only under IC_REGMUX_SCAN_EN; otherwise a plain load register inline.
- Data register and output gating stay in the top module.

## Test plan
- Reset: hold reset_n=0 with data_load=1, sel_load=1, inputs all-ones → after edge out=0, out_n=all-ones, sel_out=0, wrap=0.
- Load/select (WIDTH=4, CHANNELS=8): inputs[k]=k+1, data_load=1; sel_load sel_in=5 → next cycle out=6, out_n=4'b1001; change inputs without data_load → out stays 6.
- Enable: with out=6, enable_n=1 → same-cycle out=0, out_n=4'hF; release → out=6.
- Scan (macro on, CHANNELS=5): sel=3, scan=1 four cycles → sel_out 4,0,1,2; wrap=1 only in the cycle sel_out=0.
- Priority/out-of-range (CHANNELS=5): sel_load sel_in=6 → out=0; then scan → sel_out=0, wrap=1; sel_load=1 with scan=1 sel_in=2 → sel_out=2, wrap=0.
- Macro off: scan=1 for 10 cycles → sel_out unchanged, wrap=0 throughout.
